// File: rtl/usr_pkg.sv
// Shared opcode and FSM state types for the universal shift engine.
package usr_pkg;

    typedef enum logic [2:0] {
        USR_NOP  = 3'b000,
        USR_SHR  = 3'b001,
        USR_SHL  = 3'b010,
        USR_LOAD = 3'b011,
        USR_ROR  = 3'b100,
        USR_ROL  = 3'b101,
        USR_ASR  = 3'b110,
        USR_CLR  = 3'b111
    } usr_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } usr_state_e;

    // Everything except NOP, LOAD and CLEAR is a stepped shift/rotate.
    function automatic logic is_shift_op(input usr_op_e op);
        return !(op inside {USR_NOP, USR_LOAD, USR_CLR});
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step: the register value after one shift/rotate of op.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  usr_op_e          op,
    input  logic [WIDTH-1:0] r,
    input  logic             s_left_din,
    input  logic             s_right_din,
    output logic [WIDTH-1:0] r_next
);

    always_comb begin
        r_next = r;
        case (op)
            USR_SHR: r_next = {s_right_din, r[WIDTH-1:1]};
            USR_SHL: r_next = {r[WIDTH-2:0], s_left_din};
            USR_ROR: r_next = {r[0], r[WIDTH-1:1]};
            USR_ROL: r_next = {r[WIDTH-2:0], r[WIDTH-1]};
            USR_ASR: r_next = {r[WIDTH-1], r[WIDTH-1:1]};
            default: r_next = r;
        endcase
    end

endmodule

// File: rtl/usr_shift_engine.sv
// WIDTH-bit universal shift engine: valid/ready commands, multi-bit shifts run one step per clock.
module usr_shift_engine
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_left_din,
    input  logic             s_right_din,
    output logic [WIDTH-1:0] p_dout,
    output logic             s_left_dout,
    output logic             s_right_dout,
    output logic             busy,
    output logic             done
);

    usr_state_e       state, state_n;
    usr_op_e          op_q, op_n;
    usr_op_e          cmd_op_e;
    usr_op_e          step_op;
    logic [CNT_W-1:0] count, count_n;
    logic [CNT_W-1:0] amt_eff;
    logic [WIDTH-1:0] data_q, data_n;
    logic [WIDTH-1:0] step_out;
    logic             done_n;
    logic             accept;

    assign cmd_op_e = usr_op_e'(cmd_op);
    assign busy     = (state == ST_SHIFT);
    assign cmd_ready = !busy;
    assign accept   = cmd_valid && (state == ST_IDLE);
    assign amt_eff  = (cmd_amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_amt;

    // The accept edge steps with the live opcode; later steps use the latched one.
    assign step_op = busy ? op_q : cmd_op_e;

    assign p_dout       = data_q;
    assign s_left_dout  = data_q[WIDTH-1];
    assign s_right_dout = data_q[0];

    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op          (step_op),
        .r           (data_q),
        .s_left_din  (s_left_din),
        .s_right_din (s_right_din),
        .r_next      (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= USR_NOP;
            count  <= '0;
            data_q <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            count  <= count_n;
            data_q <= data_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op_q;
        count_n = count;
        data_n  = data_q;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_n = cmd_op_e;
                    if (!is_shift_op(cmd_op_e)) begin
                        done_n = 1'b1;
                        if (cmd_op_e == USR_LOAD) begin
                            data_n = p_din;
                        end else if (cmd_op_e == USR_CLR) begin
                            data_n = '0;
                        end
                    end else if (amt_eff == '0) begin
                        done_n = 1'b1;
                    end else begin
                        data_n = step_out;
                        if (amt_eff == CNT_W'(1)) begin
                            done_n = 1'b1;
                        end else begin
                            state_n = ST_SHIFT;
                            count_n = amt_eff - CNT_W'(1);
                        end
                    end
                end
            end
            ST_SHIFT: begin
                data_n = step_out;
                if (count == CNT_W'(1)) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                    done_n  = 1'b1;
                end else begin
                    count_n = count - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usr_shift_engine.sv
// Self-checking bench for usr_shift_engine (WIDTH=8) against a behavioural bit-level model.
module tb_usr_shift_engine;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [CNT_W-1:0] cmd_amt = '0;
    logic [WIDTH-1:0] p_din = '0;
    logic             s_left_din = 1'b0;
    logic             s_right_din = 1'b0;
    logic [WIDTH-1:0] p_dout;
    logic             s_left_dout;
    logic             s_right_dout;
    logic             busy;
    logic             done;

    int checks = 0;
    int failures = 0;
    logic [7:0] model = 8'h00;

    usr_shift_engine #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_amt      (cmd_amt),
        .p_din        (p_din),
        .s_left_din   (s_left_din),
        .s_right_din  (s_right_din),
        .p_dout       (p_dout),
        .s_left_dout  (s_left_dout),
        .s_right_dout (s_right_dout),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // One step of a shift/rotate expressed as plain arithmetic on an 8-bit value.
    function automatic logic [7:0] modelStep(input logic [2:0] op, input logic [7:0] r,
                                             input logic sl, input logic sr);
        case (op)
            3'd1:    return (r >> 1) | (sr ? 8'h80 : 8'h00);
            3'd2:    return (r << 1) | {7'd0, sl};
            3'd4:    return (r >> 1) | ((r & 8'h01) << 7);
            3'd5:    return (r << 1) | (r >> 7);
            3'd6:    return (r >> 1) | (r & 8'h80);
            default: return r;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issues one command from an idle engine and follows it cycle by cycle to its done pulse.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] din,
                                 input logic sl, input logic sr, input bit randSerial);
        int n;
        checkOutput("ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_amt = amt;
        p_din = din;
        s_left_din = sl;
        s_right_din = sr;
        if (op == 3'd0 || op == 3'd3 || op == 3'd7) n = 0;
        else n = (int'(amt) > WIDTH) ? WIDTH : int'(amt);
        @(posedge clk);
        if (op == 3'd3) model = din;
        else if (op == 3'd7) model = 8'h00;
        else if (n >= 1) model = modelStep(op, model, s_left_din, s_right_din);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_amt = 4'($urandom);
        p_din = 8'($urandom);
        for (int k = 2; k <= n; k++) begin
            if (randSerial) begin
                s_left_din = 1'($urandom);
                s_right_din = 1'($urandom);
            end
            checkOutput("busy_mid", 32'(busy), 32'd1);
            checkOutput("ready_mid", 32'(cmd_ready), 32'd0);
            checkOutput("done_mid", 32'(done), 32'd0);
            checkOutput("pdout_mid", 32'(p_dout), 32'(model));
            @(posedge clk);
            model = modelStep(op, model, s_left_din, s_right_din);
            #1;
        end
        checkOutput("busy_end", 32'(busy), 32'd0);
        checkOutput("done_end", 32'(done), 32'd1);
        checkOutput("pdout_end", 32'(p_dout), 32'(model));
        checkOutput("sleft_dout", 32'(s_left_dout), 32'(model[7]));
        checkOutput("sright_dout", 32'(s_right_dout), 32'(model[0]));
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_pdout", 32'(p_dout), 32'h00);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model = 8'h00;

        // LOAD 0xA5
        applyStimulus(3'd3, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("load_sleft", 32'(s_left_dout), 32'd1);
        checkOutput("load_sright", 32'(s_right_dout), 32'd1);
        @(posedge clk); #1;
        checkOutput("load_done_once", 32'(done), 32'd0);

        // SHR amt=3, CLEAR held valid throughout busy
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_amt = 4'd3;
        s_right_din = 1'b1;
        @(posedge clk); #1;
        cmd_op = 3'd7;
        checkOutput("shr_step1", 32'(p_dout), 32'hD2);
        checkOutput("shr_busy1", 32'(busy), 32'd1);
        checkOutput("shr_ready1", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("shr_step2", 32'(p_dout), 32'hE9);
        checkOutput("shr_busy2", 32'(busy), 32'd1);
        checkOutput("shr_ready2", 32'(cmd_ready), 32'd0);
        checkOutput("shr_nodone2", 32'(done), 32'd0);
        @(posedge clk); #1;
        checkOutput("shr_step3", 32'(p_dout), 32'hF4);
        checkOutput("shr_idle", 32'(busy), 32'd0);
        checkOutput("shr_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("held_clear", 32'(p_dout), 32'h00);
        checkOutput("held_clear_done", 32'(done), 32'd1);
        model = 8'h00;

        // ASR and clamped ROL
        applyStimulus(3'd3, 4'd0, 8'h90, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'd6, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("asr_value", 32'(p_dout), 32'hE4);
        applyStimulus(3'd3, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'd5, 4'd12, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("rol_clamped", 32'(p_dout), 32'h81);

        // SHL amt=0, NOP, SHL amt=1, then CLEAR in the done cycle
        applyStimulus(3'd3, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'd2, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("shl0_value", 32'(p_dout), 32'h3C);
        applyStimulus(3'd0, 4'd5, 8'hFF, 1'b1, 1'b1, 1'b0);
        checkOutput("nop_value", 32'(p_dout), 32'h3C);
        applyStimulus(3'd2, 4'd1, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("shl1_value", 32'(p_dout), 32'h79);
        applyStimulus(3'd7, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b_clear", 32'(p_dout), 32'h00);

        // Asynchronous reset in the middle of SHL amt=5
        applyStimulus(3'd3, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op = 3'd2;
        cmd_amt = 4'd5;
        s_left_din = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("pre_rst_pdout", 32'(p_dout), 32'hFC);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst_pdout", 32'(p_dout), 32'h00);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("inrst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        model = 8'h00;
        @(posedge clk); #1;
        checkOutput("postrst_done", 32'(done), 32'd0);
        checkOutput("postrst_pdout", 32'(p_dout), 32'h00);
        applyStimulus(3'd3, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        checkOutput("postrst_load", 32'(p_dout), 32'h5A);

        // Randomised command stream against the model
        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom), 4'($urandom), 8'($urandom),
                          1'($urandom), 1'($urandom), 1'b1);
            if (($urandom % 3) == 0) begin
                @(posedge clk); #1;
                checkOutput("rand_idle_done", 32'(done), 32'd0);
                checkOutput("rand_idle_pdout", 32'(p_dout), 32'(model));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/usr_shift_engine.md
Name: usr_shift_engine

Overview:
- Parametrised successor to the 4-bit universal shift register.
- Holds a WIDTH-bit register and executes commands through a valid/ready handshake: load, clear, no-op, and multi-bit shifts/rotates.
- A multi-bit shift/rotate of amount N runs as N single-bit steps, one per clock, with busy/done status.
- Used as a serialiser/deserialiser and bit-manipulation engine; serial inputs are sampled live on every step.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH+1), width of shift amount and step counter. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command; equals !busy.
- cmd_op  in  3  opcode, see Behaviour.
- cmd_amt  in  CNT_W  shift/rotate amount; ignored by non-shift ops.
- p_din  in  WIDTH  parallel load data.
- s_left_din  in  1  serial bit entering the LSB on SHL.
- s_right_din  in  1  serial bit entering the MSB on SHR.
- p_dout  out  WIDTH  register contents.
- s_left_dout  out  1  combinational p_dout[WIDTH-1]; the next bit to leave on a left shift.
- s_right_dout  out  1  combinational p_dout[0]; the next bit to leave on a right shift.
- busy  out  1  a multi-step shift is in progress.
- done  out  1  one-cycle pulse after the edge that completes a command.

Behaviour:
- Reset (async, rst_n=0):
  - p_dout=0, busy=0, done=0, cmd_ready=1, state=IDLE, counter=0.
  - Applies mid-operation too: the in-flight command is abandoned and done is not pulsed.
- Opcodes:
  - 000 NOP: no change.
  - 001 SHR: {s_right_din, r[W-1:1]}.
  - 010 SHL: {r[W-2:0], s_left_din}.
  - 011 LOAD: r = p_din.
  - 100 ROR: {r[0], r[W-1:1]}.
  - 101 ROL: {r[W-2:0], r[W-1]}.
  - 110 ASR: {r[W-1], r[W-1:1]}.
  - 111 CLEAR: r = 0.
- Accept: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_op is latched at accept; cmd_op and cmd_amt changes while busy are ignored.
- NOP, LOAD, CLEAR: take effect on the accept edge. done=1 for the following cycle. busy stays 0.
- Shift ops (001, 010, 100, 101, 110), effective amount N = min(cmd_amt, WIDTH):
  - N=0: register unchanged; done pulses after the accept edge; busy stays 0.
  - N=1: one step on the accept edge; done pulses next cycle; busy stays 0.
  - N>=2: step 1 on the accept edge, then state=SHIFT, busy=1, counter=N-1. Each subsequent edge performs one step and decrements the counter. The edge that performs step N returns to IDLE and clears busy; done pulses in the cycle after it.
  - Total: p_dout is final N edges after and including the accept edge. busy is high for N-1 cycles.
- Serial inputs are sampled at each step edge, not latched at accept.
- States: IDLE -> SHIFT (shift op with N>=2); SHIFT -> SHIFT while counter>1; SHIFT -> IDLE when counter==1; any state -> IDLE on reset.
- Back-to-back: a new command may be accepted in the same cycle that done is high, since cmd_ready is already 1.
- cmd_valid is ignored while busy; no error or flag is raised.
- done is registered, never combinational from cmd_valid.

Decomposition:
- Package usr_pkg:
  - op enum: USR_NOP, USR_SHR, USR_SHL, USR_LOAD, USR_ROR, USR_ROL, USR_ASR, USR_CLR.
  - state enum: ST_IDLE, ST_SHIFT.
- Sub-module usr_shift_step: purely combinational; takes (op, r, s_left_din, s_right_din) and returns the next-step value. Instanced once; the top-level module holds the FSM, counter and registers.

Test Plan (WIDTH=8):
- Reset, then LOAD p_din=0xA5 -> p_dout=0xA5 after the accept edge; done high 1 cycle; busy never high; s_left_dout=1, s_right_dout=1.
- From 0xA5: SHR amt=3, s_right_din=1 -> p_dout 0xD2, 0xE9, 0xF4 on successive edges; busy high 2 cycles; cmd_ready low during those cycles; done pulses once; a cmd_valid CLEAR held during busy is not accepted until ready returns.
- From 0x90: ASR amt=2 -> 0xE4. From 0x81: ROL amt=12 (clamped to 8) -> 0x81 after 8 edges; busy 7 cycles.
- SHL amt=0 and NOP on 0x3C -> p_dout stays 0x3C; each pulses done the cycle after accept; busy stays 0.
- SHL amt=1 with s_left_din=1 on 0x3C -> 0x79. Immediately follow with CLEAR accepted in the done cycle -> 0x00 on the next edge.
- Start SHL amt=5 on 0xFF, assert rst_n=0 asynchronously mid-cycle after 2 steps -> p_dout=0, busy=0, done stays 0, cmd_ready=1. After release, LOAD 0x5A -> 0x5A.
